mul_result_collector: RTL and testbench
=======================================

# mul_result_collector

Output-side stage directly downstream of `mul_tree_bf16`. It captures the four per-lane bf16 results, which arrive with independent strobes, into lane holding registers. Once every lane active for the current mode holds a result, it packs them into one word and buffers the word in a small FIFO. The FIFO drains over a valid/ready interface toward the result writer and memory.

## Interface
- `DW`, 16: lane result width (bf16)
- `DEPTH`, 8: FIFO entries, power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mode`  in  2  tree mode, same encoding as `mul_tree_bf16`: 00 = 4 lanes active, 01 = lanes 0 and 2 active, 10 = lane 0 only, 11 = treated as 00
- `res_in`  in  4*DW  lane results; lane i occupies bits [i*DW +: DW]
- `res_stb`  in  4  per-lane result strobe, one-cycle pulse per result
- `out_data`  out  4*DW  packed group; inactive lanes read 0
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `err_ovf`  out  1  sticky overflow flag
- `clr_err`  in  1  synchronous clear of `err_ovf`

## Operation
- Lane holding: each lane has a data register and a `full` bit.
  - `res_stb[i]` with lane i empty: capture `res_in` lane i and set `full`.
  - Strobe on a lane that is not active in the latched mode: ignored, no error.
- Mode latch: `mode` is sampled into `mode_q` only on edges where all lane `full` bits are clear and no strobe is present. Changes during a partial group are deferred until that group is pushed.
- Group complete: every active lane of `mode_q` has `full` = 1, evaluated on registered state.
- Push: on a group-complete cycle where the FIFO is not full, or is full and popping in the same cycle:
  - the packed word is written with inactive lanes forced to 0;
  - all lane `full` bits are cleared.
  - If the FIFO is full and not popping, the group stays in the holding registers and the push retries each cycle.
- Same-edge recapture: a strobe on a lane at the same edge that lane is pushed is captured into the freshly emptied register. This is not an overflow.
- Overflow: a strobe on an active lane that is full and not being pushed that edge:
  - the new value is dropped and the held value is kept;
  - `err_ovf` is set.
- `err_ovf` priority: clear by `rst` or `clr_err`. When set and clear occur on the same edge, set wins.
- FIFO: first-word-fall-through.
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop may occur on the same edge at any occupancy, including full, leaving `count` unchanged.
  - Pointers wrap modulo DEPTH.
  - `out_data` holds stable while `out_valid && !out_ready`.

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid`=0, `count`=0, `err_ovf`=0, `out_data`=0;
  - all lane `full`=0, FIFO pointers 0, `mode_q`=00.
- Latency: the last strobe of a group is sampled at edge E0, the push happens at E1, and `out_valid` rises after E1 when the FIFO was empty. This is 2 cycles from strobe to valid.
- Throughput: one group per cycle when strobes arrive every cycle and `out_ready`=1.
- `count` updates on the push/pop edge. `out_valid` = (`count` != 0).
- Reset asserted mid-group or with a non-empty FIFO discards all data. No output persists past reset.

## Test plan
- Mode 00, all four strobes together at E0 with lanes 0x3F80, 0x4000, 0x4040, 0x4080 -> `out_valid` after E1, `out_data`=0x408040404000_3F80 packed, `count`=1, then 0 after the pop.
- Mode 01, strobes staggered: lane 0 = 0x3F80 at E0, lane 2 = 0xC000 at E3, lane 1 strobed at E1 -> push at E4, `out_data` lanes {0, 0xC000, 0, 0x3F80}, lane 1 ignored, `err_ovf`=0.
- Mode 00 with `out_ready`=0, 9 back-to-back groups with DEPTH=8 -> `count` saturates at 8 and the ninth group is held. The next strobe on lane 0 sets `err_ovf`. Raising `out_ready` drains the 8 groups, then the held group, all in order.
- Full FIFO with `out_ready`=1 and a completing group on the same edge -> `count` stays 8 and the data order is preserved across pointer wrap.
- Change `mode` 00->10 while lanes 0 and 1 are full -> the group completes only after lanes 2 and 3 arrive under mode 00, and the following group uses mode 10 (lane-0-only words).
- Assert `rst` with 3 entries queued and a partial group held -> `out_valid`=0, `count`=0, `err_ovf`=0 immediately, and the next clean group is output correctly.

Source files
------------

// File: rtl/mul_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mul_result_collector
// Purpose  : Collects the four per-lane bf16 results of mul_tree_bf16, which
//            arrive with independent strobes, into lane holding registers.
//            When every lane active for the latched mode holds a result the
//            lanes are packed into one word and pushed into a first-word-
//            fall-through FIFO that drains over a valid/ready interface.
// Ports    : clk, rst (async, active-high)
//            mode       - tree mode (00/11 all lanes, 01 lanes 0+2, 10 lane 0)
//            res_in     - lane results, lane i at [i*DW +: DW]
//            res_stb    - per-lane one-cycle result strobes
//            out_data   - FIFO head, inactive lanes read 0
//            out_valid  - FIFO head valid
//            out_ready  - consumer accepts head
//            count      - FIFO occupancy
//            err_ovf    - sticky lane overflow flag
//            clr_err    - synchronous clear of err_ovf
// Revision : 1.0 - initial release
// ============================================================================
module mul_result_collector #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [4*DW-1:0]          res_in,
  input  logic [3:0]               res_stb,
  output logic [4*DW-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_ovf,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

  // Lane enable pattern for a latched mode; 11 behaves like 00.
  function automatic logic [3:0] active_mask(input logic [1:0] m);
    case (m)
      2'b01:   return 4'b0101;
      2'b10:   return 4'b0001;
      default: return 4'b1111;
    endcase
  endfunction

  logic [1:0]           mode_q, mode_d;
  logic [3:0]           full_q, full_d;
  logic [3:0][DW-1:0]   lane_q, lane_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [4*DW-1:0]      mem_q [DEPTH];

  logic [3:0]           active;
  logic                 group_complete;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 ovf_set;
  logic [4*DW-1:0]      packed_word;

  always_comb begin
    active         = active_mask(mode_q);
    group_complete = ((full_q & active) == active);
    fifo_full      = (count_q == C_FULL_COUNT);
    pop            = (count_q != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push           = group_complete && (!fifo_full || pop);

    packed_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (active[i]) begin
        packed_word[i*DW +: DW] = lane_q[i];
      end
    end

    full_d  = full_q;
    lane_d  = lane_q;
    ovf_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (push) begin
        full_d[i] = 1'b0;
      end
      if (res_stb[i] && active[i]) begin
        // A lane being pushed this edge is free to take the new result.
        if (!full_q[i] || push) begin
          full_d[i] = 1'b1;
          lane_d[i] = res_in[i*DW +: DW];
        end else begin
          ovf_set = 1'b1;
        end
      end
    end

    // Set has priority over clear.
    if (ovf_set) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Mode only changes between groups, so a partial group keeps its mode.
    if ((full_q == 4'b0000) && (res_stb == 4'b0000)) begin
      mode_d = mode;
    end else begin
      mode_d = mode_q;
    end

    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 2'b00;
      full_q   <= 4'b0000;
      lane_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      full_q   <= full_d;
      lane_q   <= lane_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the output mux hides stale entries when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= packed_word;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign err_ovf   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_result_collector
// Purpose  : Directed-vector bench for mul_result_collector. Expected packed
//            words are queued when the completing strobes are issued; a
//            monitor pops and compares on every accepted output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_result_collector;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [63:0] res_in = '0;
  logic [3:0]  res_stb = 4'b0000;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic [3:0]  count;
  logic        err_ovf;

  logic [63:0] exp_q [$];
  int          n_checks = 0;
  int          n_fails  = 0;

  mul_result_collector #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .res_in    (res_in),
    .res_stb   (res_stb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .err_ovf   (err_ovf),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] stb, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    res_in  = {d3, d2, d1, d0};
    res_stb = stb;
    step();
    res_stb = 4'b0000;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL out_data: unexpected word %h, no word expected", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [63:0] w;
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err", 64'(err_ovf), 64'd0);
    check("rst_data", out_data, 64'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Mode 00, all four lanes at once: two-cycle latency
    exp_q.push_back(64'h4080_4040_4000_3F80);
    drive(4'b1111, 16'h3F80, 16'h4000, 16'h4040, 16'h4080);
    check("t1_valid_e0", 64'(out_valid), 64'd0);
    step();
    check("t1_valid_e1", 64'(out_valid), 64'd1);
    check("t1_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_count_pop", 64'(count), 64'd0);

    // Mode 01, staggered strobes, inactive lane 1 ignored
    mode = 2'b01;
    step();
    drive(4'b0001, 16'h3F80, 16'h0000, 16'h0000, 16'h0000);
    drive(4'b0010, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
    step();
    exp_q.push_back(64'h0000_C000_0000_3F80);
    drive(4'b0100, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    check("t2_count_e3", 64'(count), 64'd0);
    step();
    check("t2_count_e4", 64'(count), 64'd1);
    check("t2_err", 64'(err_ovf), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_count_pop", 64'(count), 64'd0);

    // Mode 00, nine groups into an 8-deep FIFO with no consumer
    mode = 2'b00;
    step();
    for (int g = 0; g < 9; g++) begin
      w = {16'((g+1)*256 + 3), 16'((g+1)*256 + 2), 16'((g+1)*256 + 1), 16'((g+1)*256)};
      exp_q.push_back(w);
      drive(4'b1111, w[15:0], w[31:16], w[47:32], w[63:48]);
    end
    step();
    check("t3_count_sat", 64'(count), 64'd8);
    check("t3_err_clear", 64'(err_ovf), 64'd0);
    drive(4'b0001, 16'hDEAD, 16'h0000, 16'h0000, 16'h0000);
    check("t3_err_ovf", 64'(err_ovf), 64'd1);
    check("t3_count_held", 64'(count), 64'd8);
    out_ready = 1'b1;
    step();
    check("t4_full_push_pop", 64'(count), 64'd8);
    repeat (8) step();
    out_ready = 1'b0;
    check("t3_drained", 64'(count), 64'd0);
    check("t3_valid_low", 64'(out_valid), 64'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_err", 64'(err_ovf), 64'd0);

    // Overflow and clear on the same edge: set wins
    drive(4'b0001, 16'h5555, 16'h0000, 16'h0000, 16'h0000);
    clr_err = 1'b1;
    drive(4'b0001, 16'h6666, 16'h0000, 16'h0000, 16'h0000);
    clr_err = 1'b0;
    check("set_wins", 64'(err_ovf), 64'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_after_set", 64'(err_ovf), 64'd0);
    exp_q.push_back(64'h7773_7772_7771_5555);
    drive(4'b1110, 16'h0000, 16'h7771, 16'h7772, 16'h7773);
    step();
    check("held_value_push", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Mode change during a partial group is deferred
    drive(4'b0011, 16'hA000, 16'hB000, 16'h0000, 16'h0000);
    mode = 2'b10;
    step();
    exp_q.push_back(64'hD000_C000_B000_A000);
    drive(4'b1100, 16'h0000, 16'h0000, 16'hC000, 16'hD000);
    step();
    step();
    exp_q.push_back(64'h0000_0000_0000_1111);
    drive(4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    exp_q.push_back(64'h0000_0000_0000_2468);
    drive(4'b0001, 16'h2468, 16'h0000, 16'h0000, 16'h0000);
    step();
    check("t5_count", 64'(count), 64'd3);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    check("t5_drained", 64'(count), 64'd0);

    // Throughput: one group per cycle with the consumer always ready
    mode = 2'b00;
    step();
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      w = {16'(16'hE000 + g*16 + 3), 16'(16'hE000 + g*16 + 2),
           16'(16'hE000 + g*16 + 1), 16'(16'hE000 + g*16)};
      exp_q.push_back(w);
      drive(4'b1111, w[15:0], w[31:16], w[47:32], w[63:48]);
    end
    check("tput_count", 64'(count), 64'd1);
    step(); step();
    out_ready = 1'b0;
    check("tput_drained", 64'(count), 64'd0);

    // Reset with queued entries, a partial group and a set error flag
    drive(4'b1111, 16'h0101, 16'h0102, 16'h0103, 16'h0104);
    drive(4'b1111, 16'h0201, 16'h0202, 16'h0203, 16'h0204);
    drive(4'b1111, 16'h0301, 16'h0302, 16'h0303, 16'h0304);
    step();
    check("t6_count_pre", 64'(count), 64'd3);
    drive(4'b0001, 16'h0401, 16'h0000, 16'h0000, 16'h0000);
    drive(4'b0001, 16'h0501, 16'h0000, 16'h0000, 16'h0000);
    check("t6_err_pre", 64'(err_ovf), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_err", 64'(err_ovf), 64'd0);
    check("t6_rst_data", out_data, 64'd0);
    step();
    rst = 1'b0;
    exp_q.push_back(64'h0004_0003_0002_0001);
    drive(4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    step();
    check("t6_count_post", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t6_drained", 64'(count), 64'd0);

    repeat (3) step();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      stimulus();
      monitor();
      begin
        #200000;
        n_checks++;
        n_fails++;
        $display("FAIL watchdog: time limit reached, stimulus incomplete");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
